// File: rtl/column_window_writer.sv
// -----------------------------------------------------------------------------
// column_window_writer
//
// Consumer end of the row-buffer column stream. Each accepted K-pixel column is
// shifted into a KxK window register; once a band row has delivered at least K
// columns, every further column completes a window whose box sum is written to
// the output memory in raster order. done is raised once the final write has
// left the two-stage pipeline and stays high until the next start.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      begins an image (honoured in IDLE and DONE only)
//   col_valid  col_in carries a valid column this cycle
//   col_in     K pixels; LS slice = oldest (top) row, MS slice = newest row
//   col_ready  high while RUN; accept = col_valid && col_ready
//   wr_en      output memory write strobe (one cycle per window)
//   wr_addr    output memory address, row-major window index
//   wr_data    KxK box sum, zero-extended; holds when wr_en=0
//   done       image complete, held until the next start
// -----------------------------------------------------------------------------
module column_window_writer #(
    parameter int K               = 3,
    parameter int PIXEL_WIDTH     = 8,
    parameter int IMG_WIDTH       = 16,
    parameter int IMG_HEIGHT      = 16,
    parameter int SUM_WIDTH       = 12,
    parameter int OMEM_ADDR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       col_valid,
    input  logic [K*PIXEL_WIDTH-1:0]   col_in,
    output logic                       col_ready,
    output logic                       wr_en,
    output logic [OMEM_ADDR_WIDTH-1:0] wr_addr,
    output logic [SUM_WIDTH-1:0]       wr_data,
    output logic                       done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int BW = $clog2(IMG_HEIGHT - K + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                     r_state;
    logic [CW-1:0]              r_col_cnt;
    logic [BW-1:0]              r_band_cnt;
    logic [OMEM_ADDR_WIDTH-1:0] r_wr_cnt;
    logic                       r_col_ready;
    logic                       r_emit;
    logic                       r_wr_en;
    logic [OMEM_ADDR_WIDTH-1:0] r_wr_addr;
    logic [SUM_WIDTH-1:0]       r_wr_data;
    logic                       r_done;

    // r_win[c][r]: column c (0 = oldest), row r (0 = top).
    logic [PIXEL_WIDTH-1:0]     r_win [K][K];

    logic                       w_accept;
    logic                       w_last_col;
    logic                       w_last_band;
    logic [SUM_WIDTH-1:0]       w_sum;

    assign w_accept    = col_valid && r_col_ready;
    assign w_last_col  = (r_col_cnt == CW'(IMG_WIDTH - 1));
    assign w_last_band = (r_band_cnt == BW'(IMG_HEIGHT - K));

    // NOTE: w_sum is given a default before the loop accumulates into it with
    // blocking assignments; without the default this block would infer a latch.
    always_comb begin
        w_sum = '0;
        for (int c = 0; c < K; c++) begin
            for (int r = 0; r < K; r++) begin
                w_sum = w_sum + SUM_WIDTH'(r_win[c][r]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_col_cnt   <= '0;
            r_band_cnt  <= '0;
            r_wr_cnt    <= '0;
            r_col_ready <= 1'b0;
            r_emit      <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_done      <= 1'b0;
            // NOTE: the window is a small flop array, not a RAM, so it can be
            // cleared in reset like any other register.
            for (int c = 0; c < K; c++) begin
                for (int r = 0; r < K; r++) begin
                    r_win[c][r] <= '0;
                end
            end
        end else begin
            // Second pipeline stage: register the sum of the window completed
            // on the previous edge, together with its address.
            r_emit  <= 1'b0;
            r_wr_en <= r_emit;
            if (r_emit) begin
                r_wr_data <= w_sum;
                r_wr_addr <= r_wr_cnt;
                r_wr_cnt  <= r_wr_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_col_ready <= 1'b1;
                        r_done      <= 1'b0;
                        r_col_cnt   <= '0;
                        r_band_cnt  <= '0;
                        r_wr_cnt    <= '0;
                    end
                end

                S_RUN: begin
                    if (w_accept) begin
                        for (int c = 0; c < K - 1; c++) begin
                            r_win[c] <= r_win[c + 1];
                        end
                        for (int r = 0; r < K; r++) begin
                            r_win[K-1][r] <= col_in[r*PIXEL_WIDTH +: PIXEL_WIDTH];
                        end
                        // Windows never span bands: the first K-1 columns of a
                        // band only refill the window.
                        r_emit <= (r_col_cnt >= CW'(K - 1));
                        if (w_last_col) begin
                            r_col_cnt  <= '0;
                            r_band_cnt <= r_band_cnt + 1'b1;
                            if (w_last_band) begin
                                r_state     <= S_FLUSH;
                                r_col_ready <= 1'b0;
                            end
                        end else begin
                            r_col_cnt <= r_col_cnt + 1'b1;
                        end
                    end
                end

                S_FLUSH: begin
                    // Leave once both pipeline stages are empty.
                    if (!r_emit && !r_wr_en) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign col_ready = r_col_ready;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign done      = r_done;

endmodule

// File: tb/tb_column_window_writer.sv
module tb_column_window_writer;

    localparam int K    = 3;
    localparam int PW   = 8;
    localparam int W    = 16;
    localparam int H    = 16;
    localparam int SW   = 12;
    localparam int AW   = 8;
    localparam int WPB  = W - K + 1;          // windows per band
    localparam int NB   = H - K + 1;          // bands
    localparam int NWIN = WPB * NB;           // 196

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          col_valid;
    logic [K*PW-1:0] col_in;
    logic          col_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [SW-1:0] wr_data;
    logic          done;

    column_window_writer #(
        .K(K), .PIXEL_WIDTH(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
        .SUM_WIDTH(SW), .OMEM_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .col_valid(col_valid),
        .col_in(col_in), .col_ready(col_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / bookkeeping ----------------
    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int pat;        // 0 all ones, 1 pixel=x, 2 pixel=y, 3 random
        int gap_pct;    // percentage of idle cycles on col_valid
        int start_mid;  // pulse start in the middle of RUN
        int exp_writes;
        int exp_first;  // -1: not checked
        int exp_last;   // -1: not checked
    } vec_t;

    int  total = 0;
    int  bad   = 0;
    wr_t exp_q[$];
    int  pix [H][W];
    int  n_writes;
    int  first_data;
    int  last_data;
    int  last_exp_data;
    int  cyc = 0;
    int  last_wr_cyc = 0;
    logic       tb_acc_cmp = 1'b0;
    logic [1:0] hist = 2'b00;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Box sum straight from the image definition.
    function automatic int win_sum(input int b, input int x0);
        int s = 0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                s += pix[b + r][x0 + c];
        return s;
    endfunction

    function automatic void fill_image(input int pat);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                case (pat)
                    0:       pix[y][x] = 1;
                    1:       pix[y][x] = x;
                    2:       pix[y][x] = y;
                    default: pix[y][x] = int'($urandom_range(255));
                endcase
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) hist <= 2'b00;
        else        hist <= {hist[0], tb_acc_cmp};
    end

    // Output monitor: every write must match the next expected window, and a
    // write must appear exactly two edges after a window-completing accept.
    always @(negedge clk) begin
        if (wr_en || hist[1])
            check("wr_timing", int'(wr_en), int'(hist[1]));
        if (wr_en) begin
            n_writes++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("spurious_wr", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", int'(wr_addr), e.addr);
                check("wr_data", int'(wr_data), e.data);
                if (first_data < 0) first_data = e.data;
                last_data     = int'(wr_data);
                last_exp_data = e.data;
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drive_cols(input int gap_pct, input int start_mid, input int ncols);
        for (int idx = 0; idx < ncols; idx++) begin
            int  b     = idx / W;
            int  x     = idx % W;
            bit  acc   = 1'b0;
            int  stall = 0;
            logic [K*PW-1:0] c;
            for (int r = 0; r < K; r++) c[r*PW +: PW] = PW'(pix[b + r][x]);
            while (!acc) begin
                col_valid  = (int'($urandom_range(99)) >= gap_pct);
                col_in     = col_valid ? c : K*PW'($urandom);
                start      = (start_mid != 0) && (idx == 50);
                acc        = col_valid && col_ready;
                tb_acc_cmp = acc && (x >= K - 1);
                @(posedge clk);
                if (acc && x >= K - 1) begin
                    wr_t e;
                    e.addr = b * WPB + (x - (K - 1));
                    e.data = win_sum(b, x - (K - 1));
                    exp_q.push_back(e);
                end
                @(negedge clk);
                stall++;
                if (stall > 500) begin
                    $display("FAIL col_accept_timeout actual=%0d expected=<=500", stall);
                    $fatal(1, "column never accepted");
                end
            end
        end
        col_valid  = 1'b0;
        start      = 1'b0;
        tb_acc_cmp = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_rise", int'(done), 1);
        check("done_latency", cyc - last_wr_cyc, 2);
        check("col_ready_done", int'(col_ready), 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic reset_counts();
        n_writes   = 0;
        first_data = -1;
        last_data  = -1;
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{0,  0, 0, NWIN,  9,   9};
        vecs[1] = '{1,  0, 0, NWIN,  9, 126};
        vecs[2] = '{1, 50, 0, NWIN,  9, 126};
        vecs[3] = '{2, 50, 1, NWIN,  9, 126};
        vecs[4] = '{3, 30, 0, NWIN, -1,  -1};

        rst_n = 1'b0; start = 1'b0; col_valid = 1'b0; col_in = '0;
        reset_counts();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col_ready", int'(col_ready), 0);
        check("rst_wr_en",     int'(wr_en),     0);
        check("rst_wr_addr",   int'(wr_addr),   0);
        check("rst_wr_data",   int'(wr_data),   0);
        check("rst_done",      int'(done),      0);
        rst_n = 1'b1;

        // col_valid in IDLE is ignored.
        col_valid = 1'b1; col_in = '1;
        repeat (4) @(negedge clk);
        check("idle_col_ready", int'(col_ready), 0);
        col_valid = 1'b0;

        // ---- table-driven images ----
        for (int i = 0; i < 5; i++) begin
            fill_image(vecs[i].pat);
            reset_counts();
            pulse_start();
            check("run_done_low", int'(done), 0);
            drive_cols(vecs[i].gap_pct, vecs[i].start_mid, NB * W);
            wait_done();
            check("n_writes", n_writes, vecs[i].exp_writes);
            if (vecs[i].exp_first >= 0) check("first_data", first_data, vecs[i].exp_first);
            if (vecs[i].exp_last  >= 0) check("last_data",  last_data,  vecs[i].exp_last);
        end

        // ---- DONE ignores col_valid; wr_data holds; restart ----
        col_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            col_in = K*PW'($urandom);
            @(negedge clk);
        end
        col_valid = 1'b0;
        check("done_held", int'(done), 1);
        check("wr_data_hold", int'(wr_data), last_exp_data);
        fill_image(0);
        reset_counts();
        pulse_start();
        check("restart_done_clr", int'(done), 0);
        check("restart_col_ready", int'(col_ready), 1);
        drive_cols(0, 0, NB * W);
        wait_done();
        check("n_writes_restart", n_writes, NWIN);

        // ---- reset mid-image ----
        fill_image(1);
        reset_counts();
        pulse_start();
        drive_cols(20, 0, 100);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        col_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            col_in = K*PW'($urandom);
            @(negedge clk);
        end
        col_valid = 1'b0;
        check("postrst_col_ready", int'(col_ready), 0);
        check("postrst_done",      int'(done),      0);
        check("postrst_wr_en",     int'(wr_en),     0);
        fill_image(3);
        reset_counts();
        pulse_start();
        drive_cols(10, 0, NB * W);
        wait_done();
        check("n_writes_postrst", n_writes, NWIN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
